// File: rtl/kxk_window_gen.sv
// kxk_window_gen: assembles KxK pixel windows from a stream of vertical columns.
// Optional macro KXK_WINDOW_EDGE_REPLICATE_EN: emit from the first column, replicating the left edge.
module kxk_window_gen #(
    parameter int DATA_W = 8,
    parameter int K      = 3,
    parameter int X_W    = 11,
    parameter int Y_W    = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [K*DATA_W-1:0]   in_col,
    input  logic [X_W-1:0]        in_x,
    input  logic [Y_W-1:0]        in_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [K*K*DATA_W-1:0] out_win,
    output logic [X_W-1:0]        out_x,
    output logic [Y_W-1:0]        out_y
);
    localparam int COL_W  = K*DATA_W;
    localparam int WIN_W  = K*COL_W;
    localparam int FILL_W = $clog2(K);

    logic [COL_W-1:0] hist_q [K-1];
    logic [COL_W-1:0] hist_d [K-1];
    logic [COL_W-1:0] eff_hist [K-1];
    logic             new_line_q;
    logic             out_valid_q;
    logic [WIN_W-1:0] out_win_q;
    logic [WIN_W-1:0] out_win_d;
    logic [X_W-1:0]   out_x_q;
    logic [Y_W-1:0]   out_y_q;
    logic             line_start;
    logic             accept;
    logic             emit;

    assign in_ready   = !reset && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign line_start = (in_x == '0) || new_line_q;

    assign out_valid = out_valid_q;
    assign out_win   = out_win_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;

`ifdef KXK_WINDOW_EDGE_REPLICATE_EN
    assign emit = 1'b1;
`else
    // Count of real columns held in history; windows only leave once it is full.
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;

    assign emit   = !line_start && (fill_q == FILL_W'(K-1)) && (in_x >= X_W'(K-1));
    assign fill_d = line_start ? FILL_W'(1) :
                    (fill_q == FILL_W'(K-1)) ? fill_q : fill_q + FILL_W'(1);
`endif

    always_comb begin
        for (int i = 0; i < K-1; i++) begin
`ifdef KXK_WINDOW_EDGE_REPLICATE_EN
            eff_hist[i] = line_start ? in_col : hist_q[i];
`else
            eff_hist[i] = line_start ? '0 : hist_q[i];
`endif
        end
        for (int i = 0; i < K-2; i++) begin
            hist_d[i] = eff_hist[i+1];
        end
        hist_d[K-2] = in_col;
        out_win_d = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K-1; c++) begin
                out_win_d[(r*K+c)*DATA_W +: DATA_W] = eff_hist[c][r*DATA_W +: DATA_W];
            end
            out_win_d[(r*K+K-1)*DATA_W +: DATA_W] = in_col[r*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < K-1; i++) begin
                hist_q[i] <= '0;
            end
            new_line_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_win_q   <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
`ifndef KXK_WINDOW_EDGE_REPLICATE_EN
            fill_q      <= '0;
`endif
        end else begin
            if (accept) begin
                for (int i = 0; i < K-1; i++) begin
                    hist_q[i] <= hist_d[i];
                end
                new_line_q <= 1'b0;
`ifndef KXK_WINDOW_EDGE_REPLICATE_EN
                fill_q     <= fill_d;
`endif
            end
            // A new window may replace the one being consumed in the same cycle.
            if (accept && emit) begin
                out_valid_q <= 1'b1;
                out_win_q   <= out_win_d;
                out_x_q     <= in_x;
                out_y_q     <= in_y;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_kxk_window_gen.sv
// tb_kxk_window_gen: directed and randomized checks of kxk_window_gen against a line-level model.
// Honours KXK_WINDOW_EDGE_REPLICATE_EN the same way as the design.
module tb_kxk_window_gen;
    localparam int DW  = 8;
    localparam int K   = 3;
    localparam int XW  = 11;
    localparam int YW  = 10;
    localparam int CW  = K*DW;
    localparam int WW  = K*K*DW;
    localparam int DW5 = 10;
    localparam int K5  = 5;
    localparam int CW5 = K5*DW5;
    localparam int WW5 = K5*K5*DW5;
`ifdef KXK_WINDOW_EDGE_REPLICATE_EN
    localparam bit REPLICATE = 1'b1;
`else
    localparam bit REPLICATE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] in_col;
    logic [XW-1:0] in_x, out_x;
    logic [YW-1:0] in_y, out_y;
    logic [WW-1:0] out_win;

    logic           in_valid5, in_ready5, out_valid5, out_ready5;
    logic [CW5-1:0] in_col5;
    logic [XW-1:0]  in_x5, out_x5;
    logic [YW-1:0]  in_y5, out_y5;
    logic [WW5-1:0] out_win5;

    always #5 clk = ~clk;

    kxk_window_gen #(.DATA_W(DW), .K(K), .X_W(XW), .Y_W(YW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_col(in_col), .in_x(in_x), .in_y(in_y), .out_valid(out_valid),
        .out_ready(out_ready), .out_win(out_win), .out_x(out_x), .out_y(out_y)
    );

    kxk_window_gen #(.DATA_W(DW5), .K(K5), .X_W(XW), .Y_W(YW)) dut5 (
        .clk(clk), .reset(reset), .in_valid(in_valid5), .in_ready(in_ready5),
        .in_col(in_col5), .in_x(in_x5), .in_y(in_y5), .out_valid(out_valid5),
        .out_ready(out_ready5), .out_win(out_win5), .out_x(out_x5), .out_y(out_y5)
    );

    int errors = 0;
    int checks = 0;
    int seenValid = 0;
    bit lastAccept;

    // Model: the columns of the current line (last K kept) plus the expected output registers.
    logic [CW-1:0] lineCols [$];
    bit            newLine = 1'b1;
    logic          modelValid = 1'b0;
    logic [WW-1:0] modelWin = '0;
    logic [XW-1:0] modelX = '0;
    logic [YW-1:0] modelY = '0;

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Window = last K columns of the line; short lines pad on the left with the line's first column.
    function automatic logic [WW-1:0] modelWindow();
        logic [WW-1:0] w;
        logic [CW-1:0] col;
        int            n;
        int            idx;
        w = '0;
        n = lineCols.size();
        for (int c = 0; c < K; c++) begin
            idx = n - K + c;
            if (idx < 0) idx = 0;
            col = lineCols[idx];
            for (int r = 0; r < K; r++) begin
                w[(r*K+c)*DW +: DW] = col[r*DW +: DW];
            end
        end
        return w;
    endfunction

    task automatic applyStimulus(input logic v, input logic [CW-1:0] col, input logic [XW-1:0] x,
                                 input logic [YW-1:0] y, input logic rdy, input logic rst);
        logic expReady;
        logic acc;
        logic emit;
        in_valid  = v;
        in_col    = col;
        in_x      = x;
        in_y      = y;
        out_ready = rdy;
        reset     = rst;
        #1;
        expReady = !rst && (!modelValid || rdy);
        checkOutput("in_ready", in_ready, expReady);
        acc  = v && expReady;
        emit = 1'b0;
        @(posedge clk);
        #1;
        if (rst) begin
            modelValid = 1'b0;
            modelWin   = '0;
            modelX     = '0;
            modelY     = '0;
            lineCols.delete();
            newLine    = 1'b1;
        end else begin
            if (acc) begin
                if (x == '0 || newLine) lineCols.delete();
                newLine = 1'b0;
                lineCols.push_back(col);
                if (lineCols.size() > K) void'(lineCols.pop_front());
                if (lineCols.size() == K || REPLICATE) begin
                    emit     = 1'b1;
                    modelWin = modelWindow();
                    modelX   = x;
                    modelY   = y;
                end
            end
            if (emit) modelValid = 1'b1;
            else if (modelValid && rdy) modelValid = 1'b0;
        end
        lastAccept = acc;
        checkOutput("out_valid", out_valid, modelValid);
        checkOutput("out_win", out_win, modelWin);
        checkOutput("out_x", out_x, modelX);
        checkOutput("out_y", out_y, modelY);
        if (out_valid) seenValid++;
    endtask

    function automatic logic [CW-1:0] rampCol(input int x, input int base);
        return {8'(base + x + 8'h21), 8'(base + x + 8'h11), 8'(base + x + 1)};
    endfunction

    initial begin
        logic [23:0] topExp [5];
        int          base;
        int          curX;
        int          curY;
        int          lineW;
        int          win5;
        logic [9:0]  pix;

        in_valid5 = 1'b0; in_col5 = '0; in_x5 = '0; in_y5 = '0; out_ready5 = 1'b1;

        applyStimulus(0, '0, 0, 0, 1, 1);
        applyStimulus(0, '0, 0, 0, 1, 1);

        $display("[TB] basic line x=0..4");
        topExp[0] = REPLICATE ? 24'h010101 : 24'h000000;
        topExp[1] = REPLICATE ? 24'h020101 : 24'h000000;
        topExp[2] = 24'h030201;
        topExp[3] = 24'h040302;
        topExp[4] = 24'h050403;
        base = seenValid;
        for (int x = 0; x < 5; x++) begin
            applyStimulus(1, rampCol(x, 0), XW'(x), 0, 1, 0);
            checkOutput("top_row", out_win[23:0], topExp[x]);
            if (x >= 2) checkOutput("basic_x", out_x, XW'(x));
        end
        checkOutput("basic_count", seenValid - base, REPLICATE ? 5 : 3);
        applyStimulus(0, '0, 0, 0, 1, 0);

        $display("[TB] backpressure stall");
        applyStimulus(0, '0, 0, 0, 1, 1);
        for (int x = 0; x < 3; x++) applyStimulus(1, rampCol(x, 0), XW'(x), 0, 1, 0);
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1, rampCol(3, 0), 3, 0, 0, 0);
            checkOutput("stall_x", out_x, 2);
            checkOutput("stall_top", out_win[23:0], 24'h030201);
        end
        for (int x = 3; x < 6; x++) begin
            applyStimulus(1, rampCol(x, 0), XW'(x), 0, 1, 0);
            if (x == 3) checkOutput("resume_x", out_x, 3);
        end
        applyStimulus(0, '0, 0, 0, 1, 0);

        $display("[TB] line change");
        applyStimulus(0, '0, 0, 0, 1, 1);
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 4; x++) begin
                applyStimulus(1, rampCol(x, y*8'h40), XW'(x), YW'(y), 1, 0);
                if (y == 1 && x == 2) begin
                    checkOutput("line_y", out_y, 1);
                    checkOutput("line_top", out_win[23:0], 24'h434241);
                end
            end
        end
        applyStimulus(0, '0, 0, 0, 1, 0);

        $display("[TB] mid-line reset");
        applyStimulus(0, '0, 0, 0, 1, 1);
        for (int x = 0; x < 3; x++) applyStimulus(1, rampCol(x, 0), XW'(x), 0, 1, 0);
        applyStimulus(1, rampCol(3, 0), 3, 0, 1, 1);
        checkOutput("rst_valid", out_valid, 0);
        base = seenValid;
        applyStimulus(1, rampCol(4, 0), 4, 0, 1, 0);
        applyStimulus(1, rampCol(5, 0), 5, 0, 1, 0);
        checkOutput("rst_count", seenValid - base, REPLICATE ? 2 : 0);
        applyStimulus(1, rampCol(6, 0), 6, 0, 1, 0);
        checkOutput("rst_emit", out_valid, 1);
        checkOutput("rst_x", out_x, 6);

        $display("[TB] randomized stream");
        curX  = 0;
        curY  = 0;
        lineW = 5;
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, CW'($urandom), XW'(curX), YW'(curY),
                          $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
            if (lastAccept) begin
                if (curX + 1 >= lineW) begin
                    curX  = 0;
                    curY  = curY + 1;
                    lineW = $urandom_range(1, 8);
                end else begin
                    curX = curX + 1;
                end
            end
        end
        applyStimulus(0, '0, 0, 0, 1, 0);
        applyStimulus(0, '0, 0, 0, 1, 0);

        $display("[TB] K=5 stream");
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        win5 = 0;
        for (int x = 0; x < 8; x++) begin
            in_valid5 = 1'b1;
            for (int r = 0; r < K5; r++) in_col5[r*DW5 +: DW5] = 10'(r*100 + x + 1);
            in_x5 = XW'(x);
            in_y5 = 3;
            @(posedge clk);
            #1;
            checkOutput("k5_valid", out_valid5, REPLICATE || x >= 4);
            if (REPLICATE || x >= 4) begin
                checkOutput("k5_x", out_x5, XW'(x));
                checkOutput("k5_y", out_y5, 3);
                pix = 10'(4*100 + x + 1);
                checkOutput("k5_e44", out_win5[(4*K5+4)*DW5 +: DW5], pix);
                pix = 10'(((x >= 4) ? x - 4 : 0) + 1);
                checkOutput("k5_e00", out_win5[0 +: DW5], pix);
            end
            if (out_valid5) win5++;
        end
        in_valid5 = 1'b0;
        checkOutput("k5_count", win5, REPLICATE ? 8 : 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/kxk_window_gen.md
KXK_WINDOW_GEN -- requirements
Module: kxk_window_gen

Interface
REQ-001 Parameter DATA_W, default 8, pixel width in bits.
REQ-002 Parameter K, default 3, window size; legal values 3, 5 and 7.
REQ-003 Parameter X_W, default 11, column coordinate width.
REQ-004 Parameter Y_W, default 10, row coordinate width.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port in_valid, input, 1 bit: upstream column present.
REQ-008 Port in_ready, output, 1 bit: block accepts a column this cycle.
REQ-009 Port in_col, input, K*DATA_W bits: vertical column from the line buffer; row r at bits [r*DATA_W +: DATA_W], r=0 top.
REQ-010 Port in_x, input, X_W bits: column coordinate of in_col.
REQ-011 Port in_y, input, Y_W bits: row coordinate of in_col.
REQ-012 Port out_valid, output, 1 bit: window present.
REQ-013 Port out_ready, input, 1 bit: downstream accepts the window.
REQ-014 Port out_win, output, K*K*DATA_W bits: element (r,c) at bits [(r*K+c)*DATA_W +: DATA_W]; c=0 oldest column, c=K-1 newest column.
REQ-015 Port out_x, output, X_W bits: in_x of the newest column in out_win.
REQ-016 Port out_y, output, Y_W bits: in_y of the newest column in out_win.

Function
REQ-017 A column SHALL be accepted when in_valid and in_ready are both 1 in the same cycle.
REQ-018 in_ready SHALL be combinational: 0 while reset=1, otherwise (!out_valid || out_ready).
REQ-019 The block SHALL hold K-1 history columns h[0..K-2], h[0] oldest; on each accept, h[0..K-3] SHALL take h[1..K-2] and h[K-2] SHALL take in_col.
REQ-020 On an accept with in_x==0, history SHALL first be cleared to zero, so the new line never mixes with the previous line.
REQ-021 On an emitting accept, out_win SHALL load {h[0..K-2], in_col}, using the pre-shift history, and out_x/out_y SHALL load in_x/in_y.
REQ-022 Latency SHALL be 1 cycle: out_valid rises on the edge that accepts an emitting column.
REQ-023 With out_valid=1 and out_ready=0, out_win, out_x and out_y SHALL stay stable and no column SHALL be accepted.
REQ-024 Simultaneous handshakes (out_valid&&out_ready together with an emitting accept) SHALL keep out_valid=1 and load the new window in the same cycle, sustaining one window per cycle.
REQ-025 When out_valid&&out_ready occurs with no emitting accept, out_valid SHALL fall to 0.
REQ-026 Non-emitting accepts SHALL update history only and leave the output registers unchanged.
REQ-027 in_x wrap-around to 0 at any value SHALL be treated as a line start; no maximum image width is assumed.

Reset
REQ-028 While reset=1 at a clock edge: out_valid=0, out_win=0, out_x=0, out_y=0, and all history columns=0.
REQ-029 Reset mid-stream SHALL discard any pending window and history; the first accept after reset is treated as a new line regardless of in_x.

Configuration
REQ-030 Macro KXK_WINDOW_EDGE_REPLICATE_EN absent: only accepts with in_x >= K-1 are emitting; zero-cleared history is never exposed.
REQ-031 Macro KXK_WINDOW_EDGE_REPLICATE_EN defined: every accept is emitting; at in_x==0 all history columns are loaded with in_col instead of zero, and out_win replicates the left-edge column into c=0..K-2.

Verification
REQ-032 K=3, macro off, row-0 values x+1 for x=0..4, out_ready=1: exactly 3 windows, with out_x=2,3,4 and top row {1,2,3},{2,3,4},{3,4,5}.
REQ-033 K=3, macro on, same stimulus: 5 windows; the x=0 top row is {1,1,1} and the x=1 top row is {1,1,2}.
REQ-034 Hold out_ready=0 for 4 cycles after the first window: in_ready=0, and out_win and out_x are unchanged; the stream resumes with no loss or duplication.
REQ-035 Line change: x=0..3 on y=0, then x=0..3 on y=1, macro off: no window contains a y=0 pixel once y=1 data arrives; out_y=1 from out_x=2.
REQ-036 Assert reset for 1 cycle mid-line at x=3, then resume at x=4, macro off: out_valid=0 after reset, and no window is emitted until 2 further accepts.
REQ-037 K=5, DATA_W=10, continuous stream of 8 columns, macro off: 4 windows with out_x=4..7, and element (4,4) equals the row-4 pixel of the newest column.
